// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the FIFO read-side drain engine
package fifo_pkg;

    localparam int         DATA_SIZE_DEF = 32;
    localparam logic [1:0] SKID_DEPTH    = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read port plus outgoing valid/ready stream
interface fifo_rd_stream_if #(
    parameter int DATA_SIZE = fifo_pkg::DATA_SIZE_DEF
);

    logic                 f_empty;
    logic [DATA_SIZE-1:0] f_rdata;
    logic                 f_ren;
    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_SIZE-1:0] m_data;
    logic                 m_last;

    // master: the drain engine; slave: the FIFO and downstream consumer
    modport master (
        input  f_empty,
        input  f_rdata,
        input  m_ready,
        output f_ren,
        output m_valid,
        output m_data,
        output m_last
    );

    modport slave (
        output f_empty,
        output f_rdata,
        output m_ready,
        input  f_ren,
        input  m_valid,
        input  m_data,
        input  m_last
    );

endinterface

// File: rtl/fifo_rd_stream_skid_buf2.sv
// rtl/fifo_rd_stream_skid_buf2.sv - two-entry register FIFO; head entry drives dout
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int WIDTH = DATA_SIZE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (occ != 2'd0);
    assign push_ok = push && ((occ != SKID_DEPTH) || pop_ok);
    assign dout    = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10: begin
                    if (occ == 2'd0) head <= din;
                    else             tail <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == SKID_DEPTH) head <= tail;
                    occ <= occ - 2'd1;
                end
                // Simultaneous push and pop keeps occupancy; the new word queues behind.
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains the async FIFO read port into a packetised valid/ready stream
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int PKT_LEN   = 16,
    parameter int CNT_SIZE  = 16
) (
    input  logic                r_clk,
    input  logic                r_rstn,
    input  logic                en,
    fifo_rd_stream_if.master    s,
    output logic [CNT_SIZE-1:0] pkt_cnt,
    output logic                busy
);

    localparam int BCNT_W = (clog2(PKT_LEN) > 1) ? clog2(PKT_LEN) : 1;
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(PKT_LEN - 1);

    logic [1:0]        occ;
    logic              beat;
    logic [BCNT_W-1:0] bcnt;

    // Pop decision uses only registered occupancy, never m_ready; held off during reset.
    assign s.f_ren   = r_rstn && en && !s.f_empty && (occ < SKID_DEPTH);
    assign s.m_valid = (occ != 2'd0);
    assign beat      = s.m_valid && s.m_ready;
    assign s.m_last  = s.m_valid && (bcnt == LAST_BEAT);
    assign busy      = s.m_valid || (bcnt != '0);

    skid_buf2 #(
        .WIDTH (DATA_SIZE)
    ) u_skid (
        .clk   (r_clk),
        .rst_n (r_rstn),
        .push  (s.f_ren),
        .din   (s.f_rdata),
        .pop   (beat),
        .dout  (s.m_data),
        .occ   (occ)
    );

    always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            bcnt    <= '0;
            pkt_cnt <= '0;
        end else if (beat) begin
            if (bcnt == LAST_BEAT) begin
                bcnt    <= '0;
                pkt_cnt <= pkt_cnt + 1'b1;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

    localparam int DW = 32;
    localparam int PL = 4;
    localparam int CW = 16;

    logic r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT A: PKT_LEN=4, CNT_SIZE=16 ----------------
    logic          r_rstn;
    logic          en;
    logic          hold_empty;
    logic [CW-1:0] pkt_cnt;
    logic          busy;

    fifo_rd_stream_if #(.DATA_SIZE(DW)) ifa ();

    logic [DW-1:0] src_mem [0:2047];
    int src_wr = 0;
    int src_rd = 0;

    assign ifa.f_empty = (src_rd == src_wr) || hold_empty;
    assign ifa.f_rdata = src_mem[src_rd];

    fifo_rd_stream #(.DATA_SIZE(DW), .PKT_LEN(PL), .CNT_SIZE(CW)) dut_a (
        .r_clk   (r_clk),
        .r_rstn  (r_rstn),
        .en      (en),
        .s       (ifa),
        .pkt_cnt (pkt_cnt),
        .busy    (busy)
    );

    // ---------------- DUT B: PKT_LEN=1, CNT_SIZE=2 ----------------
    logic       rstn_b;
    logic       en_b;
    logic [1:0] pkt_cnt_b;
    logic       busy_b;

    fifo_rd_stream_if #(.DATA_SIZE(DW)) ifb ();

    fifo_rd_stream #(.DATA_SIZE(DW), .PKT_LEN(1), .CNT_SIZE(2)) dut_b (
        .r_clk   (r_clk),
        .r_rstn  (rstn_b),
        .en      (en_b),
        .s       (ifb),
        .pkt_cnt (pkt_cnt_b),
        .busy    (busy_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge r_clk);
        #1;
    endtask

    // Model: words taken from the FIFO and not yet delivered, plus beats since reset.
    logic [DW-1:0] mq [$];
    int            beats = 0;
    logic [DW-1:0] out_data [$];
    logic          out_last [$];

    always @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            mq.delete();
            beats = 0;
        end else begin
            logic m_beat;
            logic m_pop;
            m_beat = (mq.size() != 0) && ifa.m_ready;
            m_pop  = en && !ifa.f_empty && (mq.size() < 2);
            if (ifa.m_valid && ifa.m_ready) begin
                out_data.push_back(ifa.m_data);
                out_last.push_back(ifa.m_last);
            end
            if (ifa.f_ren && !ifa.f_empty) src_rd <= src_rd + 1;
            if (m_beat) begin
                void'(mq.pop_front());
                beats = beats + 1;
            end
            if (m_pop) mq.push_back(ifa.f_rdata);
        end
    end

    always @(negedge r_clk) begin
        logic exp_valid;
        exp_valid = (mq.size() != 0);
        chk("m_valid", 64'(ifa.m_valid), 64'(exp_valid));
        if (exp_valid) chk("m_data", 64'(ifa.m_data), 64'(mq[0]));
        chk("m_last", 64'(ifa.m_last), 64'(exp_valid && ((beats % PL) == PL - 1)));
        chk("pkt_cnt", 64'(pkt_cnt), 64'((beats / PL) % 65536));
        chk("busy", 64'(busy), 64'(exp_valid || ((beats % PL) != 0)));
        chk("f_ren", 64'(ifa.f_ren),
            64'(r_rstn && en && !ifa.f_empty && (mq.size() < 2)));
        chk("underflow", 64'(ifa.f_ren && ifa.f_empty), 64'(0));
    end

    int exp6 [5] = '{1, 2, 3, 0, 1};

    initial begin
        int base;
        int bad;
        r_rstn      = 1'b0;
        en          = 1'b1;
        hold_empty  = 1'b0;
        ifa.m_ready = 1'b1;
        rstn_b      = 1'b0;
        en_b        = 1'b0;
        ifb.f_empty = 1'b1;
        ifb.f_rdata = 32'h5a;
        ifb.m_ready = 1'b0;

        // 1: reset state, then first pop on release
        for (int i = 0; i < 8; i++) begin
            src_mem[src_wr] = 32'(i);
            src_wr = src_wr + 1;
        end
        step(2);
        chk("t1_rst_fren", 64'(ifa.f_ren), 64'(0));
        chk("t1_rst_valid", 64'(ifa.m_valid), 64'(0));
        chk("t1_rst_pkt", 64'(pkt_cnt), 64'(0));
        chk("t1_rst_busy", 64'(busy), 64'(0));
        r_rstn = 1'b1;
        #1;
        chk("t1_fren_release", 64'(ifa.f_ren), 64'(1));
        chk("t1_valid_before", 64'(ifa.m_valid), 64'(0));
        step(1);
        chk("t1_valid_after", 64'(ifa.m_valid), 64'(1));
        chk("t1_data_after", 64'(ifa.m_data), 64'(0));

        // 2: streaming two packets
        for (int k = 0; k < 50 && out_data.size() < 8; k++) step(1);
        chk("t2_count", 64'(out_data.size()), 64'(8));
        for (int i = 0; i < 8 && i < out_data.size(); i++) begin
            chk("t2_data", 64'(out_data[i]), 64'(i));
            chk("t2_last", 64'(out_last[i]), 64'((i == 3) || (i == 7)));
        end
        chk("t2_pkt", 64'(pkt_cnt), 64'(2));
        chk("t2_busy", 64'(busy), 64'(0));

        // 3: backpressure
        out_data.delete();
        out_last.delete();
        ifa.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            src_mem[src_wr] = 32'(i);
            src_wr = src_wr + 1;
        end
        for (int c = 0; c < 5; c++) begin
            step(1);
            chk("t3_hold_data", 64'(ifa.m_data), 64'(0));
            chk("t3_hold_valid", 64'(ifa.m_valid), 64'(1));
        end
        chk("t3_fren_full", 64'(ifa.f_ren), 64'(0));
        ifa.m_ready = 1'b1;
        for (int k = 0; k < 50 && out_data.size() < 8; k++) step(1);
        chk("t3_count", 64'(out_data.size()), 64'(8));
        for (int i = 0; i < 8 && i < out_data.size(); i++)
            chk("t3_order", 64'(out_data[i]), 64'(i));
        chk("t3_pkt", 64'(pkt_cnt), 64'(4));

        // 4: random empty flag and random backpressure
        out_data.delete();
        out_last.delete();
        base = src_wr;
        for (int i = 0; i < 1000; i++) begin
            src_mem[src_wr] = $urandom;
            src_wr = src_wr + 1;
        end
        for (int k = 0; k < 20000 && out_data.size() < 1000; k++) begin
            hold_empty  = ($urandom_range(0, 2) == 0);
            ifa.m_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        hold_empty  = 1'b0;
        ifa.m_ready = 1'b1;
        step(2);
        chk("t4_count", 64'(out_data.size()), 64'(1000));
        bad = 0;
        for (int i = 0; i < 1000 && i < out_data.size(); i++)
            if (out_data[i] !== src_mem[base + i]) bad = bad + 1;
        chk("t4_stream", 64'(bad), 64'(0));
        chk("t4_pkt", 64'(pkt_cnt), 64'(254));

        // 5: enable pause mid-packet
        out_data.delete();
        out_last.delete();
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            src_mem[src_wr] = 32'ha0 + 32'(i);
            src_wr = src_wr + 1;
        end
        step(1);
        chk("t5_fren_off", 64'(ifa.f_ren), 64'(0));
        en = 1'b1;
        step(2);
        en = 1'b0;
        #1;
        chk("t5_fren_stop", 64'(ifa.f_ren), 64'(0));
        step(3);
        chk("t5_drained", 64'(out_data.size()), 64'(2));
        chk("t5_valid_idle", 64'(ifa.m_valid), 64'(0));
        chk("t5_busy_mid", 64'(busy), 64'(1));
        chk("t5_pkt_mid", 64'(pkt_cnt), 64'(254));
        en = 1'b1;
        for (int k = 0; k < 50 && out_data.size() < 8; k++) step(1);
        chk("t5_count", 64'(out_data.size()), 64'(8));
        for (int i = 0; i < 8 && i < out_data.size(); i++) begin
            chk("t5_data", 64'(out_data[i]), 64'(32'ha0 + 32'(i)));
            chk("t5_last", 64'(out_last[i]), 64'((i == 3) || (i == 7)));
        end
        chk("t5_pkt", 64'(pkt_cnt), 64'(256));
        chk("t5_busy_end", 64'(busy), 64'(0));

        // 6: counter wrap with PKT_LEN=1, then asynchronous reset
        ifb.f_empty = 1'b0;
        ifb.m_ready = 1'b1;
        en_b        = 1'b1;
        rstn_b      = 1'b1;
        step(1);
        chk("t6_valid", 64'(ifb.m_valid), 64'(1));
        chk("t6_last", 64'(ifb.m_last), 64'(1));
        chk("t6_pkt0", 64'(pkt_cnt_b), 64'(0));
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("t6_pkt_seq", 64'(pkt_cnt_b), 64'(exp6[k]));
        end
        #2;
        rstn_b = 1'b0;
        #1;
        chk("t6_async_valid", 64'(ifb.m_valid), 64'(0));
        chk("t6_async_pkt", 64'(pkt_cnt_b), 64'(0));
        chk("t6_async_busy", 64'(busy_b), 64'(0));
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
